// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and types for the CNN datapath blocks.
// Holds the kernel tap count, tap-index width, default weight width and the
// state encoding used by weight_serializer.
package cnn_pkg;

    localparam int N_TAPS     = 9;
    localparam int TAP_W      = 4;
    localparam int PASS_W     = 16;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_SEND = SEND,
        S_DONE = DONE
    } ser_state_t;

endpackage

// File: rtl/weight_serializer.sv
// weight_serializer: snapshots nine parallel kernel weights on start and
// streams them out one per valid/ready handshake, replaying the 9-tap
// sequence REPEAT times per job.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, w_valid    job request; accepted only in IDLE with w_valid high
//   w_0 .. w_8        parallel weights, captured at job start
//   m_data, m_tap     current weight and its tap index
//   m_last            tap 8 of the final pass
//   m_valid, m_ready  stream handshake
//   busy, done        job in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start with w_valid
// SEND  | streaming snapshot, idx = tap, pass = replay count
// DONE  | one-cycle done pulse, then back to IDLE
module weight_serializer
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REPEAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              w_valid,
    input  logic [DATA_W-1:0] w_0,
    input  logic [DATA_W-1:0] w_1,
    input  logic [DATA_W-1:0] w_2,
    input  logic [DATA_W-1:0] w_3,
    input  logic [DATA_W-1:0] w_4,
    input  logic [DATA_W-1:0] w_5,
    input  logic [DATA_W-1:0] w_6,
    input  logic [DATA_W-1:0] w_7,
    input  logic [DATA_W-1:0] w_8,
    output logic [DATA_W-1:0] m_data,
    output logic [3:0]        m_tap,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(N_TAPS - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(REPEAT - 1);

    ser_state_t        state, state_nxt;
    logic [TAP_W-1:0]  idx, idx_nxt;
    logic [PASS_W-1:0] pass, pass_nxt;
    logic              capture;
    logic              hs;
    logic [DATA_W-1:0] snap [N_TAPS];

    // m_valid is a flop, so m_ready never reaches it combinationally.
    assign hs = m_valid & m_ready;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pass_nxt  = pass;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && w_valid) begin
                    state_nxt = S_SEND;
                    idx_nxt   = '0;
                    pass_nxt  = '0;
                    capture   = 1'b1;
                end
            end
            S_SEND: begin
                if (hs) begin
                    if (idx != LAST_TAP) begin
                        idx_nxt = idx + 1'b1;
                    end else if (pass != LAST_PASS) begin
                        idx_nxt  = '0;
                        pass_nxt = pass + 1'b1;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next-state values so they line
    // up with the state they describe without any decode after the flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            pass    <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            pass    <= pass_nxt;
            m_valid <= (state_nxt == S_SEND);
            m_last  <= (state_nxt == S_SEND) && (idx_nxt == LAST_TAP) &&
                       (pass_nxt == LAST_PASS);
            busy    <= (state_nxt != S_IDLE);
            done    <= (state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_TAPS; i++) snap[i] <= '0;
        end else if (capture) begin
            snap[0] <= w_0;
            snap[1] <= w_1;
            snap[2] <= w_2;
            snap[3] <= w_3;
            snap[4] <= w_4;
            snap[5] <= w_5;
            snap[6] <= w_6;
            snap[7] <= w_7;
            snap[8] <= w_8;
        end
    end

    assign m_tap = idx;

    always_comb begin
        m_data = '0;
        if (idx < TAP_W'(N_TAPS)) m_data = snap[idx];
    end

endmodule

// File: doc/weight_serializer.md
# weight_serializer

Converts the nine parallel 32-bit kernel weights produced by the weight loader into a serial stream, one weight per handshake, for the downstream MAC. It sits between the weight loader's parallel `w_0`..`w_8`/`load_done` outputs and the convolution datapath. It snapshots the weights on `start`. It can replay the 9-tap sequence `REPEAT` times per start, for example once per output pixel.

## Interface
Parameters:
- `DATA_W`, 32, width of each weight word.
- `REPEAT`, 1, number of complete 9-tap passes per `start`. Legal range 1..65535.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request one serialization job.
- `w_valid`  in  1  upstream weights valid; driven from the loader's `load_done`.
- `w_0` .. `w_8`  in  DATA_W each  parallel kernel weights, tap 0..8.
- `m_data`  out  DATA_W  current weight.
- `m_tap`  out  4  tap index of `m_data`, 0..8.
- `m_last`  out  1  high with tap 8 of the final pass.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready from consumer.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse when a job completes.

## Operation
- States: IDLE, SEND, DONE.
- IDLE → SEND when `start && w_valid`:
  - All nine `w_n` are copied into internal snapshot registers.
  - Tap counter `idx` = 0 and pass counter `pass` = 0.
- In IDLE, `start` with `w_valid` low is ignored.
- In SEND, `start` is ignored.
- Changes on `w_n` after capture do not affect the running job.
- SEND:
  - `m_valid` = 1.
  - `m_data` = snap[`idx`] and `m_tap` = `idx`.
  - `m_last` = (`idx`==8 && `pass`==REPEAT-1).
- A handshake is a cycle with `m_valid && m_ready`. On a handshake:
  - If `idx` < 8: `idx`++.
  - If `idx` == 8 and `pass` < REPEAT-1: `idx` = 0 and `pass`++.
  - If `idx` == 8 and `pass` == REPEAT-1: go to DONE.
- Stream rule: while `m_valid` && !`m_ready`, `m_data`, `m_tap` and `m_last` hold stable.
- `m_valid` never drops before the final handshake.
- DONE:
  - `done` = 1 and `m_valid` = 0 for exactly one cycle.
  - Then unconditional return to IDLE.
  - `start` in DONE is ignored.
- `busy` = (state != IDLE).
- `pass` is 16 bits wide; `idx` is 4 bits.
- Reset values:
  - State IDLE.
  - `m_valid`, `m_last`, `busy` and `done` = 0.
  - `m_tap` = 0 and `m_data` = 0.
  - All snapshot registers = 0.
- Reset mid-job: all outputs return to reset values asynchronously. The job is discarded and a new `start` is required.

## Timing
- `start` sampled high in cycle T (with `w_valid` high):
  - `busy` and `m_valid` are high from T+1, with tap 0.
- With `m_ready` held high, taps advance one per cycle. The final handshake is at cycle T+9·REPEAT.
- `done` pulses at T+9·REPEAT+1. IDLE is reached at T+9·REPEAT+2, which is the earliest next accepted `start`.
- Each cycle of `m_ready` low during SEND extends the job by one cycle.
- Output paths:
  - `m_data` is a combinational mux of registered `idx` and snapshot; no combinational path from `w_n`.
  - `m_valid`, `m_last`, `m_tap`, `busy` and `done` come from registers only.
  - `m_ready` → `m_valid` has no combinational path.

## Structure
- Shared package `cnn_pkg` (extends the existing one if present) holds:
  - Constant `N_TAPS` = 9.
  - Tap-index width 4.
  - State encoding localparams IDLE/SEND/DONE.
  - Default `DATA_W` = 32.
- No sub-module: one FSM plus two counters and a 9-entry snapshot register file.
- A top-level pairing with the weight loader is outside this block.

## Test plan
- Single pass, `REPEAT`=1:
  - Stimulus: `w_n` = n+1 (`w_0`=1 .. `w_8`=9), `w_valid`=1, `start` pulse at T, `m_ready`=1.
  - Required: `m_data` 1..9 on cycles T+1..T+9, `m_tap` 0..8, `m_last` only at T+9, `done` at T+10, `busy` low at T+11.
- Backpressure:
  - Stimulus: as above with `m_ready` low at cycles T+3 and T+4.
  - Required: `m_data`=3, `m_tap`=2 held stable through T+5, `done` at T+12.
- Snapshot isolation:
  - Stimulus: change all `w_n` to 32'hDEADBEEF at T+2.
  - Required: stream still 1..9.
- Ignore rules:
  - `start` with `w_valid`=0 → no `busy`, `m_valid` stays 0.
  - `start` during SEND → no restart; tap sequence unbroken.
  - `start` in DONE cycle → ignored.
- Repeat:
  - Stimulus: `REPEAT`=3.
  - Required: 27 beats, sequence 1..9 ×3, `m_last` only on beat 27, `done` at T+28.
- Reset mid-job:
  - Stimulus: assert `rst` after beat 4.
  - Required: `m_valid`, `busy`, `m_data` = 0 immediately; a new `start` restarts at tap 0.
